mul_arbiter: RTL and testbench
==============================

Name: mul_arbiter

Overview:
- Two-requester scheduler for the shared shift-add multiplier (SIZE x SIZE -> 2*SIZE).
- Accepts operand pairs from two clients and grants them round-robin.
- Drives the multiplier's valid/ack handshake and returns the product to the owning client.
- A watchdog aborts a hung operation by pulsing a dedicated multiplier reset and flagging an error to the client.

Parameters:
- SIZE, 32, operand width; product width is 2*SIZE.
- TIMEOUT, 255, max cycles spent in WAIT_DONE or WAIT_RACK before abort (must be >= 1).
- TW, 8, watchdog counter width; must hold TIMEOUT.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req0_valid  in  1  client 0 has an operand pair.
- req0_a  in  SIZE  client 0 multiplicand.
- req0_b  in  SIZE  client 0 multiplier.
- req0_ready  out  1  one-cycle pulse: client 0 pair accepted.
- req0_done  out  1  one-cycle pulse: client 0 result valid.
- req0_err  out  1  qualifies req0_done: operation aborted.
- req1_valid, req1_a, req1_b, req1_ready, req1_done, req1_err  same as client 0, for client 1.
- rsp_prod  out  2*SIZE  result bus, valid when either reqN_done is high.
- mul_a  out  SIZE  to multiplier a.
- mul_b  out  SIZE  to multiplier b.
- mul_valid  out  1  to multiplier valid_data.
- mul_ack  out  1  to multiplier ack.
- mul_rst  out  1  abort pulse; ORed with reset at the multiplier.
- mul_prod  in  2*SIZE  multiplier product.
- mul_done  in  1  multiplier Done_Flag.
- mul_ret_ack  in  1  multiplier ret_ack.

Behaviour:
- Reset: state=IDLE, last_grant=1 (client 0 wins first), wdog=0. All outputs 0, including rsp_prod, mul_a and mul_b.
- Reset mid-operation: returns to IDLE next edge, no done/err pulse; the multiplier is reset by the same reset.
- States: IDLE, WAIT_DONE, WAIT_RACK, RESP, ABORT.
- IDLE arbitration at each edge:
  - Only one reqN_valid high: grant that client.
  - Both high: grant the client != last_grant.
  - On grant: latch a/b into mul_a/mul_b, record owner, set last_grant=owner, wdog=0, go WAIT_DONE.
  - reqN_ready is high for exactly the first cycle of WAIT_DONE (registered).
- Client rule: a client must drop valid the cycle after ready, or the pair is accepted again as a new request.
- WAIT_DONE:
  - mul_valid=1; mul_a/mul_b held stable.
  - Edge with mul_done=1: capture mul_prod into rsp_prod, mul_valid=0, mul_ack=1, wdog=0, go WAIT_RACK.
  - Otherwise wdog++; if wdog reaches TIMEOUT-1 without done, go ABORT.
- WAIT_RACK:
  - mul_ack=1.
  - Edge with mul_ret_ack=1: mul_ack=0, go RESP.
  - Timeout as in WAIT_DONE -> ABORT.
- RESP: owner's reqN_done=1 and reqN_err=0 for one cycle, rsp_prod valid; next state IDLE. Requests are not sampled in RESP.
- ABORT (one cycle):
  - mul_rst=1, mul_valid=0, mul_ack=0.
  - Owner's reqN_done=1 and reqN_err=1; rsp_prod=0.
  - Next state IDLE.
- Minimum accept-to-accept spacing: grant edge, >=1 cycle WAIT_DONE, >=1 WAIT_RACK, 1 RESP, 1 IDLE.
- The non-owner's done/err/ready stay 0 throughout an operation.
- mul_done and mul_ret_ack arriving simultaneously in WAIT_DONE: take the WAIT_DONE transition only; ret_ack is re-sampled in WAIT_RACK.
- mul_done outside WAIT_DONE and mul_ret_ack outside WAIT_RACK are ignored.
- Requests arriving during any non-IDLE state wait; with both waiting, they alternate strictly.
- No combinational path from any input to any output.

Test Plan:
- Single request: req0 a=3, b=5; model multiplier asserts done 3 cycles after valid and ret_ack 1 cycle after ack. Expect req0_ready at cycle 1, mul_valid held until done, then req0_done with rsp_prod=15 and req0_err=0.
- Simultaneous requests from reset: req0 (7x6) and req1 (0xFFFFFFFF x 2), both held. Expect grant order 0,1,0,1; products 42 and 0x1_FFFFFFFE on the correct client; req1_ready never coincides with req0_done.
- Max operands: a=b=0xFFFFFFFF. Expect rsp_prod=0xFFFFFFFE00000001.
- Watchdog: mul_done never asserted, TIMEOUT=10. Expect a one-cycle ABORT: mul_rst=1, req0_done=1, req0_err=1, rsp_prod=0. The next request then completes normally.
- Reset mid-operation: assert reset during WAIT_RACK. Expect all outputs 0 next cycle and no done pulse; the next request is granted to client 0.
- Simultaneous done and ret_ack in WAIT_DONE: expect a WAIT_RACK entry with mul_ack=1; completion occurs only on a later ret_ack.

Source files
------------

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin two-client scheduler for the shared shift-add multiplier
module mul_arbiter #(
    parameter int SIZE    = 32,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [SIZE-1:0]   req0_a,
    input  logic [SIZE-1:0]   req0_b,
    output logic              req0_ready,
    output logic              req0_done,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic [SIZE-1:0]   req1_a,
    input  logic [SIZE-1:0]   req1_b,
    output logic              req1_ready,
    output logic              req1_done,
    output logic              req1_err,
    output logic [2*SIZE-1:0] rsp_prod,
    output logic [SIZE-1:0]   mul_a,
    output logic [SIZE-1:0]   mul_b,
    output logic              mul_valid,
    output logic              mul_ack,
    output logic              mul_rst,
    input  logic [2*SIZE-1:0] mul_prod,
    input  logic              mul_done,
    input  logic              mul_ret_ack
);
    typedef enum logic [2:0] {IDLE, WAIT_DONE, WAIT_RACK, RESP, ABORT} state_t;

    localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [TW-1:0]     wdog_q, wdog_d;
    logic [SIZE-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [2*SIZE-1:0] rsp_prod_q, rsp_prod_d;
    logic [1:0]        ready_q, ready_d, done_q, done_d, err_q, err_d;
    logic              mul_valid_q, mul_valid_d;
    logic              mul_ack_q, mul_ack_d;
    logic              mul_rst_q, mul_rst_d;

    logic              grant1;
    logic [1:0]        owner_oh;

    // Contention goes to the client that was not served last.
    assign grant1   = req1_valid & (~req0_valid | ~last_grant_q);
    assign owner_oh = owner_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wdog_d       = wdog_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        rsp_prod_d   = rsp_prod_q;
        ready_d      = 2'b00;
        done_d       = 2'b00;
        err_d        = 2'b00;
        mul_valid_d  = 1'b0;
        mul_ack_d    = 1'b0;
        mul_rst_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid | req1_valid) begin
                    owner_d      = grant1;
                    last_grant_d = grant1;
                    mul_a_d      = grant1 ? req1_a : req0_a;
                    mul_b_d      = grant1 ? req1_b : req0_b;
                    wdog_d       = '0;
                    ready_d      = grant1 ? 2'b10 : 2'b01;
                    mul_valid_d  = 1'b1;
                    state_d      = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (mul_done) begin
                    rsp_prod_d = mul_prod;
                    mul_ack_d  = 1'b1;
                    wdog_d     = '0;
                    state_d    = WAIT_RACK;
                end else if (wdog_q == WDOG_LAST) begin
                    mul_rst_d  = 1'b1;
                    done_d     = owner_oh;
                    err_d      = owner_oh;
                    rsp_prod_d = '0;
                    state_d    = ABORT;
                end else begin
                    wdog_d      = wdog_q + TW'(1);
                    mul_valid_d = 1'b1;
                end
            end
            WAIT_RACK: begin
                if (mul_ret_ack) begin
                    done_d  = owner_oh;
                    state_d = RESP;
                end else if (wdog_q == WDOG_LAST) begin
                    mul_rst_d  = 1'b1;
                    done_d     = owner_oh;
                    err_d      = owner_oh;
                    rsp_prod_d = '0;
                    state_d    = ABORT;
                end else begin
                    wdog_d    = wdog_q + TW'(1);
                    mul_ack_d = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            wdog_q       <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp_prod_q   <= '0;
            ready_q      <= 2'b00;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
            mul_valid_q  <= 1'b0;
            mul_ack_q    <= 1'b0;
            mul_rst_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            wdog_q       <= wdog_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            rsp_prod_q   <= rsp_prod_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            err_q        <= err_d;
            mul_valid_q  <= mul_valid_d;
            mul_ack_q    <= mul_ack_d;
            mul_rst_q    <= mul_rst_d;
        end
    end

    assign req0_ready = ready_q[0];
    assign req1_ready = ready_q[1];
    assign req0_done  = done_q[0];
    assign req1_done  = done_q[1];
    assign req0_err   = err_q[0];
    assign req1_err   = err_q[1];
    assign rsp_prod   = rsp_prod_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_valid  = mul_valid_q;
    assign mul_ack    = mul_ack_q;
    assign mul_rst    = mul_rst_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - scoreboard bench for mul_arbiter with a behavioural multiplier model
module tb_mul_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
    logic [63:0] rsp_prod;
    logic [31:0] mul_a, mul_b;
    logic        mul_valid, mul_ack, mul_rst;
    logic [63:0] mul_prod = '0;
    logic        mul_done = 1'b0;
    logic        mul_ret_ack = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [64:0] exp0[$];
    logic [64:0] exp1[$];
    int          exp_grant[$];

    int  phase = 0, cnt = 0, done_delay = 3, rack_delay = 1;
    bit  never_done = 0, simul = 0, rack_armed = 0, first1 = 0;
    int  g_mon, lat0, lat1, n;
    logic [64:0] e_mon;

    mul_arbiter #(.SIZE(32), .TIMEOUT(10), .TW(8)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready), .req0_done(req0_done), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready), .req1_done(req1_done), .req1_err(req1_err),
        .rsp_prod(rsp_prod), .mul_a(mul_a), .mul_b(mul_b),
        .mul_valid(mul_valid), .mul_ack(mul_ack), .mul_rst(mul_rst),
        .mul_prod(mul_prod), .mul_done(mul_done), .mul_ret_ack(mul_ret_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_zero();
        chk("zero_flags", {req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err,
                           mul_valid, mul_ack, mul_rst}, 0);
        chk("zero_prod", rsp_prod, 0);
        chk("zero_ops", {mul_a, mul_b}, 0);
    endtask

    task automatic send(input int c, input logic [31:0] a, input logic [31:0] b,
                        input logic [64:0] exp, input bit push_g, output int lat);
        bit seen;
        @(negedge clk);
        if (push_g) exp_grant.push_back(c);
        if (c == 0) begin
            exp0.push_back(exp); req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            exp1.push_back(exp); req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            lat++;
            seen = (c == 0) ? req0_ready : req1_ready;
        end
        if (c == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        chk("ready_seen", seen, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (exp0.size() + exp1.size() + exp_grant.size()) != 0; i++)
            @(negedge clk);
        chk("drain", exp0.size() + exp1.size() + exp_grant.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Multiplier model: done after done_delay valid cycles, ret_ack rack_delay cycles after ack.
    always @(negedge clk) begin
        if (reset || mul_rst) begin
            phase = 0; cnt = 0; mul_done = 1'b0; mul_ret_ack = 1'b0;
        end else begin
            case (phase)
                0: if (mul_valid) begin
                    cnt++;
                    if (!never_done && cnt >= done_delay) begin
                        mul_prod    = {32'b0, mul_a} * {32'b0, mul_b};
                        mul_done    = 1'b1;
                        mul_ret_ack = simul;
                        rack_armed  = 0;
                        first1      = 1;
                        cnt         = 0;
                        phase       = 1;
                    end
                end
                1: begin
                    if (simul && first1) chk("simul_ack", mul_ack, 1);
                    first1 = 0;
                    if (mul_ack) begin
                        mul_done = 1'b0; mul_ret_ack = 1'b0; cnt = 0; phase = 2;
                    end
                end
                2: begin
                    cnt++;
                    if (cnt >= rack_delay) begin
                        mul_ret_ack = 1'b1; rack_armed = 1; phase = 3;
                    end
                end
                default: if (!mul_ack) begin
                    mul_ret_ack = 1'b0; cnt = 0; phase = 0;
                end
            endcase
        end
    end

    // Output monitor and scoreboard pop.
    always @(negedge clk) begin
        if (!reset) begin
            if (req0_ready | req0_done | req1_ready | req1_done)
                chk("excl", $countones({req0_ready, req0_done, req1_ready, req1_done}), 1);
            if (req0_ready | req1_ready) begin
                chk("ready_mulvalid", mul_valid, 1);
                chk("grant_pending", exp_grant.size() != 0, 1);
                if (exp_grant.size() != 0) begin
                    g_mon = exp_grant.pop_front();
                    chk("grant_owner", req1_ready, 64'(g_mon));
                end
            end
            if (req0_done) begin
                chk("c0_pending", exp0.size() != 0, 1);
                if (exp0.size() != 0) begin
                    e_mon = exp0.pop_front();
                    chk("c0_err", req0_err, e_mon[64]);
                    chk("c0_prod", rsp_prod, e_mon[63:0]);
                    if (e_mon[64]) chk("c0_mulrst", mul_rst, 1);
                    else chk("c0_rack_order", rack_armed, 1);
                end
            end
            if (req1_done) begin
                chk("c1_pending", exp1.size() != 0, 1);
                if (exp1.size() != 0) begin
                    e_mon = exp1.pop_front();
                    chk("c1_err", req1_err, e_mon[64]);
                    chk("c1_prod", rsp_prod, e_mon[63:0]);
                    if (e_mon[64]) chk("c1_mulrst", mul_rst, 1);
                    else chk("c1_rack_order", rack_armed, 1);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zero();
        reset = 1'b0;

        send(0, 32'd3, 32'd5, {1'b0, 64'd15}, 1, lat0);
        chk("t1_ready_lat", lat0, 1);
        wait_idle();

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_grant.push_back(0); exp_grant.push_back(1);
        fork
            begin
                send(0, 32'd7, 32'd6, {1'b0, 64'd42}, 0, lat0);
                send(0, 32'd7, 32'd6, {1'b0, 64'd42}, 0, lat0);
            end
            begin
                send(1, 32'hFFFF_FFFF, 32'd2, {1'b0, 64'h1_FFFF_FFFE}, 0, lat1);
                send(1, 32'hFFFF_FFFF, 32'd2, {1'b0, 64'h1_FFFF_FFFE}, 0, lat1);
            end
        join
        wait_idle();

        send(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 64'hFFFF_FFFE_0000_0001}, 1, lat1);
        wait_idle();

        never_done = 1;
        send(0, 32'd9, 32'd9, {1'b1, 64'd0}, 1, lat0);
        n = 0;
        for (int i = 0; i < 50 && !req0_done; i++) begin
            @(negedge clk);
            n++;
        end
        chk("wdog_lat", n, 10);
        never_done = 0;
        wait_idle();
        send(0, 32'd4, 32'd4, {1'b0, 64'd16}, 1, lat0);
        wait_idle();

        rack_delay = 6;
        send(0, 32'd2, 32'd3, {1'b0, 64'd6}, 1, lat0);
        for (int i = 0; i < 50 && !mul_ack; i++) @(negedge clk);
        chk("rack_reached", mul_ack, 1);
        reset = 1'b1;
        @(negedge clk);
        check_zero();
        exp0.delete();
        rack_delay = 1;
        @(negedge clk);
        reset = 1'b0;
        exp_grant.push_back(0); exp_grant.push_back(1);
        fork
            send(0, 32'd5, 32'd5, {1'b0, 64'd25}, 0, lat0);
            send(1, 32'd6, 32'd6, {1'b0, 64'd36}, 0, lat1);
        join
        wait_idle();

        simul = 1;
        rack_delay = 3;
        send(1, 32'd11, 32'd13, {1'b0, 64'd143}, 1, lat1);
        wait_idle();
        simul = 0;
        rack_delay = 1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
